// File: rtl/imem_fetch_loader.sv
// Byte-addressed Y86-64 instruction memory with a streaming loader and a registered fetch window.
// Latency: a fetch accepted on one edge produces its result and a fetch_valid pulse in the next cycle.
// Backpressure: fetch_ready is low while loading. The loader has no stall; bytes that arrive when memory is full are dropped and flagged.
module imem_fetch_loader #(
  parameter int DEPTH       = 1024,
  parameter int FETCH_BYTES = 10,
  parameter int PC_W        = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ld_valid,
  input  logic [7:0]                     ld_data,
  input  logic                           ld_last,
  output logic [$clog2(DEPTH+1)-1:0]     ld_count,
  output logic                           ld_err,
  output logic                           run,
  input  logic                           fetch_req,
  input  logic [PC_W-1:0]                fetch_pc,
  output logic                           fetch_ready,
  output logic                           fetch_valid,
  output logic [7:0]                     byte0,
  output logic [8*(FETCH_BYTES-1)-1:0]   byte_rest,
  output logic                           imem_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = 8 * (FETCH_BYTES - 1);

  // Highest PC whose whole window still lies inside the array. Comparing
  // against this avoids ever forming pc + FETCH_BYTES, which could wrap.
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - FETCH_BYTES);
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Storage has no reset: program contents survive rst_n.
  logic [7:0] mem_q [DEPTH];

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] ld_count_q, ld_count_d;
  logic          ld_err_q, ld_err_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  logic          fetch_valid_q, fetch_valid_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [RW-1:0] rest_q, rest_d;
  logic          err_q, err_d;

  logic          accept;
  logic          pc_err;
  logic [AW-1:0] base;
  logic [7:0]    win0;
  logic [RW-1:0] win_rest;

  // Loader: store the next byte while space remains, otherwise record the overflow; ld_last ends LOAD.
  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    ld_err_d   = ld_err_q;
    mem_we     = 1'b0;
    mem_waddr  = ld_count_q[AW-1:0];
    if (state_q == ST_LOAD && ld_valid) begin
      if (ld_count_q < FULL) begin
        mem_we     = 1'b1;
        ld_count_d = ld_count_q + CW'(1);
      end else begin
        ld_err_d = 1'b1;
      end
      if (ld_last) begin
        state_d = ST_RUN;
      end
    end
  end

  // Memory write port, driven only by the loader.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= ld_data;
    end
  end

  // Window read: byte0 at pc, then pc+1 in the top byte of byte_rest down to pc+FETCH_BYTES-1 in the bottom byte.
  always_comb begin
    base     = fetch_pc[AW-1:0];
    win0     = mem_q[base];
    win_rest = '0;
    for (int i = 1; i < FETCH_BYTES; i++) begin
      win_rest[(FETCH_BYTES-1-i)*8 +: 8] = mem_q[base + AW'(i)];
    end
  end

  // Fetch result: capture on acceptance, hold otherwise; out-of-range windows return zero data with imem_err.
  always_comb begin
    accept        = (state_q == ST_RUN) && fetch_req;
    pc_err        = (fetch_pc > LAST_PC);
    fetch_valid_d = accept;
    byte0_d       = byte0_q;
    rest_d        = rest_q;
    err_d         = err_q;
    if (accept) begin
      err_d   = pc_err;
      byte0_d = pc_err ? 8'h00 : win0;
      rest_d  = pc_err ? '0 : win_rest;
    end
  end

  // Control and result registers; reset aborts any load or fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      ld_count_q    <= '0;
      ld_err_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      byte0_q       <= 8'h00;
      rest_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ld_count_q    <= ld_count_d;
      ld_err_q      <= ld_err_d;
      fetch_valid_q <= fetch_valid_d;
      byte0_q       <= byte0_d;
      rest_q        <= rest_d;
      err_q         <= err_d;
    end
  end

  assign ld_count    = ld_count_q;
  assign ld_err      = ld_err_q;
  assign run         = (state_q == ST_RUN);
  assign fetch_ready = (state_q == ST_RUN);
  assign fetch_valid = fetch_valid_q;
  assign byte0       = byte0_q;
  assign byte_rest   = rest_q;
  assign imem_err    = err_q;

endmodule

// File: tb/tb_imem_fetch_loader.sv
// Directed bench for imem_fetch_loader (DEPTH=1024, FETCH_BYTES=10, PC_W=64).
// Fetch results are checked one cycle after acceptance against a byte model of the loaded program.
// Covers reset, overflow while loading, fetch gating during LOAD, range boundaries and reset retention.
module tb_imem_fetch_loader;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic [10:0] ld_count;
  logic        ld_err;
  logic        run;
  logic        fetch_req;
  logic [63:0] fetch_pc;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [7:0]  byte0;
  logic [71:0] byte_rest;
  logic        imem_err;

  imem_fetch_loader #(.DEPTH(1024), .FETCH_BYTES(10), .PC_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_count(ld_count), .ld_err(ld_err), .run(run),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .byte0(byte0), .byte_rest(byte_rest), .imem_err(imem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] mem_m [1024];

  typedef struct {
    logic [63:0] pc;
    logic        err;
  } vec_t;
  vec_t vecs [9];

  localparam logic [71:0] PROG_REST = 72'hF3_05_00_00_00_00_00_00_00;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic ld_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Expected window from the model; out-of-range windows read as zero.
  task automatic exp_window(input logic [63:0] pc, input logic err,
                            output logic [7:0] b0, output logic [71:0] rest);
    int p;
    b0   = 8'h00;
    rest = '0;
    if (!err) begin
      p  = int'(pc[9:0]);
      b0 = mem_m[p];
      for (int j = 1; j < 10; j++) rest[(9-j)*8 +: 8] = mem_m[p+j];
    end
  endtask

  task automatic fetch_chk(input string nm, input logic [63:0] pc, input logic err);
    logic [7:0]  eb0;
    logic [71:0] erest;
    exp_window(pc, err, eb0, erest);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    chk({nm, ".valid"}, 128'(fetch_valid), 128'(1'b1));
    chk({nm, ".err"},   128'(imem_err),    128'(err));
    chk({nm, ".byte0"}, 128'(byte0),       128'(eb0));
    chk({nm, ".rest"},  128'(byte_rest),   128'(erest));
  endtask

  logic [7:0] prog [10];
  logic       saw_fetch;

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    fetch_req = 1'b0; fetch_pc = '0;
    prog = '{8'h30, 8'hF3, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst.ld_count", 128'(ld_count), 128'(0));
    chk("rst.ld_err", 128'(ld_err), 128'(0));
    chk("rst.run", 128'(run), 128'(0));
    chk("rst.fetch_ready", 128'(fetch_ready), 128'(0));
    chk("rst.fetch_valid", 128'(fetch_valid), 128'(0));
    chk("rst.byte0", 128'(byte0), 128'(0));
    chk("rst.byte_rest", 128'(byte_rest), 128'(0));
    chk("rst.imem_err", 128'(imem_err), 128'(0));
    rst_n = 1'b1;

    // Overflow: 1025 bytes without ld_last, fetch requested throughout LOAD
    saw_fetch = 1'b0;
    fetch_req = 1'b1;
    fetch_pc  = 64'd0;
    for (int a = 0; a < 1025; a++) begin
      ld_byte(8'((a * 7 + 3) & 255), 1'b0);
      if (a < 1024) mem_m[a] = 8'((a * 7 + 3) & 255);
      if (fetch_valid || fetch_ready) saw_fetch = 1'b1;
      if (a == 1023) begin
        chk("fill.ld_count", 128'(ld_count), 128'(1024));
        chk("fill.ld_err", 128'(ld_err), 128'(0));
      end
    end
    fetch_req = 1'b0;
    chk("ovf.ld_count", 128'(ld_count), 128'(1024));
    chk("ovf.ld_err", 128'(ld_err), 128'(1));
    chk("ovf.run", 128'(run), 128'(0));
    chk("load.no_fetch", 128'(saw_fetch), 128'(0));

    // Reset clears counters but keeps memory
    rst_n = 1'b0;
    #1;
    chk("rst2.ld_count", 128'(ld_count), 128'(0));
    chk("rst2.ld_err", 128'(ld_err), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Program load, ld_last on the 10th byte
    for (int i = 0; i < 10; i++) begin
      ld_byte(prog[i], (i == 9));
      mem_m[i] = prog[i];
    end
    chk("prog.run", 128'(run), 128'(1));
    chk("prog.ld_count", 128'(ld_count), 128'(10));
    chk("prog.fetch_ready", 128'(fetch_ready), 128'(1));

    // First fetch, hand-computed window
    fetch_req = 1'b1;
    fetch_pc  = 64'd0;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    chk("f0.valid", 128'(fetch_valid), 128'(1));
    chk("f0.byte0", 128'(byte0), 128'(8'h30));
    chk("f0.rest", 128'(byte_rest), 128'(PROG_REST));
    chk("f0.err", 128'(imem_err), 128'(0));
    @(posedge clk); #1;
    chk("idle.valid", 128'(fetch_valid), 128'(0));
    chk("idle.byte0_hold", 128'(byte0), 128'(8'h30));

    // Back-to-back fetch table, including range boundaries
    vecs[0] = '{64'd0, 1'b0};
    vecs[1] = '{64'd1, 1'b0};
    vecs[2] = '{64'd2, 1'b0};
    vecs[3] = '{64'd1014, 1'b0};
    vecs[4] = '{64'd1015, 1'b1};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[6] = '{64'd1024, 1'b1};
    vecs[7] = '{64'd500, 1'b0};
    vecs[8] = '{64'd1013, 1'b0};
    for (int k = 0; k < 9; k++) begin
      logic [7:0]  eb0;
      logic [71:0] erest;
      exp_window(vecs[k].pc, vecs[k].err, eb0, erest);
      fetch_req = 1'b1;
      fetch_pc  = vecs[k].pc;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.valid", k), 128'(fetch_valid), 128'(1));
      chk($sformatf("vec%0d.err", k), 128'(imem_err), 128'(vecs[k].err));
      chk($sformatf("vec%0d.byte0", k), 128'(byte0), 128'(eb0));
      chk($sformatf("vec%0d.rest", k), 128'(byte_rest), 128'(erest));
    end
    fetch_req = 1'b0;
    @(posedge clk); #1;
    chk("post.valid", 128'(fetch_valid), 128'(0));

    // Loader ignored in RUN
    ld_valid = 1'b1;
    ld_data  = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    ld_valid = 1'b0;
    chk("run_ld.ld_count", 128'(ld_count), 128'(10));
    chk("run_ld.ld_err", 128'(ld_err), 128'(0));
    fetch_chk("run_ld.f0", 64'd0, 1'b0);
    chk("run_ld.rest_hand", 128'(byte_rest), 128'(PROG_REST));

    // Reset the cycle after an accepted fetch
    fetch_req = 1'b1;
    fetch_pc  = 64'd3;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    chk("abort.accepted", 128'(fetch_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("abort.valid", 128'(fetch_valid), 128'(0));
    chk("abort.run", 128'(run), 128'(0));
    chk("abort.byte0", 128'(byte0), 128'(0));
    #2;
    rst_n = 1'b1;

    // Reload a single byte (same value as before) and read retained contents
    ld_byte(8'h30, 1'b1);
    chk("reload.run", 128'(run), 128'(1));
    chk("reload.ld_count", 128'(ld_count), 128'(1));
    fetch_chk("retain.pc0", 64'd0, 1'b0);
    chk("retain.rest_hand", 128'(byte_rest), 128'(PROG_REST));
    fetch_chk("retain.pc700", 64'd700, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
